// File: rtl/cache_bus_arbiter_pkg.sv
// Shared definitions for the cache bus arbiter: FSM state encoding, requester tag IDs, line geometry.
// Latency: n/a (package).
// Backpressure: n/a (package).
package cache_bus_pkg;

  // Default number of bus beats per 64-byte cache line.
  localparam int BEATS_DEFAULT = 8;

  // Line offset bits. The address phase always carries a line-aligned address.
  localparam int LINE_OFS = 6;

  // Requester IDs. These form the low 12 bits of the bus tag.
  localparam logic [11:0] ID_IC = 12'h001;
  localparam logic [11:0] ID_DC = 12'h002;

  // FSM state enumeration. Plain constants keep the encoding visible to legacy tools.
  typedef logic [2:0] arb_state_t;
  localparam arb_state_t ST_IDLE  = 3'd0;
  localparam arb_state_t ST_ADDR  = 3'd1;
  localparam arb_state_t ST_WDATA = 3'd2;
  localparam arb_state_t ST_RDATA = 3'd3;
  localparam arb_state_t ST_DONE  = 3'd4;

  // Bus tag layout: {write-back flag, requester ID}.
  function automatic logic [12:0] make_tag(input logic we, input logic [11:0] id);
    return {we, id};
  endfunction

endpackage

// File: rtl/cache_bus_arbiter_if.sv
// Memory-side request/response bus shared by the cache arbiter (master) and the memory system (slave).
// Latency: n/a (wires only).
// Backpressure: request side is held by bus_reqack; response side is accepted by bus_respack.
// Ports: bus_reqcyc/bus_req/bus_reqtag/bus_reqack carry requests; bus_respcyc/bus_resp/bus_resptag/bus_respack carry responses.
interface cache_bus_arbiter_if #(
  parameter int WIDTH = 64,
  parameter int TAGW  = 13
) ();

  logic             bus_reqcyc;
  logic [WIDTH-1:0] bus_req;
  logic [TAGW-1:0]  bus_reqtag;
  logic             bus_reqack;

  logic             bus_respcyc;
  logic [WIDTH-1:0] bus_resp;
  logic [TAGW-1:0]  bus_resptag;
  logic             bus_respack;

  modport master (
    output bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    input  bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

  modport slave (
    input  bus_reqcyc, bus_req, bus_reqtag, bus_respack,
    output bus_reqack, bus_respcyc, bus_resp, bus_resptag
  );

endinterface

// File: rtl/cache_bus_arbiter_rr_arbiter2.sv
// Two-way grant between icache and dcache. When both request, the one not served last wins.
// Latency: combinational, 0 cycles.
// Backpressure: none; the caller samples the grant only when it can start a transaction.
// Ports: ic_req, dc_req, last_dc (1 = dcache served last) -> grant_ic, grant_dc (one-hot or zero).
// Macro ARB_FIXED_PRIO_EN: when defined, dcache always wins simultaneous requests and last_dc is ignored.
module rr_arbiter2 (
  input  logic ic_req,
  input  logic dc_req,
  input  logic last_dc,
  output logic grant_ic,
  output logic grant_dc
);

`ifdef ARB_FIXED_PRIO_EN
  logic unused_last_dc;
  assign unused_last_dc = last_dc;
  assign grant_dc       = dc_req;
`else
  // dcache loses a tie only when it was the last one served.
  assign grant_dc = dc_req & (~ic_req | ~last_dc);
`endif

  assign grant_ic = ic_req & ~grant_dc;

endmodule

// File: rtl/cache_bus_arbiter.sv
// Shares one tagged memory bus between icache line fills and dcache fills/writebacks, one line at a time.
// Latency: grant-to-address 1 cycle; fill beats are forwarded in the same cycle; done pulses 1 cycle after the last beat.
// Backpressure: the address and writeback beats are held until bus_reqack; response beats carrying a foreign tag are left unacked.
// Ports: clk, reset (sync, active-high); ic_req/ic_addr -> ic_rdata/ic_rvalid/ic_done;
//        dc_req/dc_we/dc_addr/dc_wdata -> dc_wnext/dc_rdata/dc_rvalid/dc_done; bus (cache_bus_arbiter_if.master).
// Macro ARB_FIXED_PRIO_EN (in rr_arbiter2): when defined, dcache wins simultaneous requests; otherwise round-robin.
module cache_bus_arbiter
  import cache_bus_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int BEATS = BEATS_DEFAULT,
  parameter int TAGW  = 13
) (
  input  logic                      clk,
  input  logic                      reset,

  input  logic                      ic_req,
  input  logic [WIDTH-1:0]          ic_addr,
  output logic [WIDTH-1:0]          ic_rdata,
  output logic                      ic_rvalid,
  output logic                      ic_done,

  input  logic                      dc_req,
  input  logic                      dc_we,
  input  logic [WIDTH-1:0]          dc_addr,
  input  logic [WIDTH-1:0]          dc_wdata,
  output logic                      dc_wnext,
  output logic [WIDTH-1:0]          dc_rdata,
  output logic                      dc_rvalid,
  output logic                      dc_done,

  cache_bus_arbiter_if.master       bus
);

  localparam int CW = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

  arb_state_t       state;
  logic             owner_dc;   // 1: transaction belongs to dcache
  logic             we_q;       // 1: writeback, 0: fill
  logic             last_dc;    // 1: dcache was served last
  logic [WIDTH-1:0] addr_q;
  logic [CW-1:0]    beat_cnt;

  logic             grant_ic;
  logic             grant_dc;
  logic [TAGW-1:0]  issued_tag;
  logic             resp_match;
  logic             beat_fire;
  logic             last_beat;
  logic [WIDTH-1:0] ic_line;
  logic [WIDTH-1:0] dc_line;

  // Offset bits inside a line never reach the bus.
  logic unused_addr_ofs;
  assign unused_addr_ofs = ^{ic_addr[LINE_OFS-1:0], dc_addr[LINE_OFS-1:0]};

  assign ic_line = {ic_addr[WIDTH-1:LINE_OFS], {LINE_OFS{1'b0}}};
  assign dc_line = {dc_addr[WIDTH-1:LINE_OFS], {LINE_OFS{1'b0}}};

  rr_arbiter2 u_rr_arbiter2 (
    .ic_req   (ic_req),
    .dc_req   (dc_req),
    .last_dc  (last_dc),
    .grant_ic (grant_ic),
    .grant_dc (grant_dc)
  );

  assign issued_tag = TAGW'(make_tag(we_q, owner_dc ? ID_DC : ID_IC));

  // Only responses carrying our own tag belong to this transaction.
  assign resp_match = (state == ST_RDATA) && bus.bus_respcyc && (bus.bus_resptag == issued_tag);
  assign beat_fire  = ((state == ST_WDATA) && bus.bus_reqack) || resp_match;
  assign last_beat  = (beat_cnt == LAST_BEAT);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      owner_dc <= 1'b0;
      we_q     <= 1'b0;
      last_dc  <= 1'b1;   // icache wins the first tie after reset
      addr_q   <= '0;
      beat_cnt <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (grant_ic || grant_dc) begin
            owner_dc <= grant_dc;
            we_q     <= grant_dc & dc_we;
            addr_q   <= grant_dc ? dc_line : ic_line;
            beat_cnt <= '0;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (bus.bus_reqack) begin
            state <= we_q ? ST_WDATA : ST_RDATA;
          end
        end
        ST_WDATA, ST_RDATA: begin
          if (beat_fire) begin
            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
            if (last_beat) begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: begin
          last_dc <= owner_dc;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode from state, so reset clears them all on the same edge.
  assign bus.bus_reqcyc  = (state == ST_ADDR) || (state == ST_WDATA);
  assign bus.bus_req     = (state == ST_ADDR)  ? addr_q   :
                           (state == ST_WDATA) ? dc_wdata : '0;
  assign bus.bus_reqtag  = bus.bus_reqcyc ? issued_tag : '0;
  assign bus.bus_respack = resp_match;

  assign ic_rvalid = resp_match & ~owner_dc;
  assign dc_rvalid = resp_match &  owner_dc;
  assign ic_rdata  = ic_rvalid ? bus.bus_resp : '0;
  assign dc_rdata  = dc_rvalid ? bus.bus_resp : '0;

  assign ic_done   = (state == ST_DONE) & ~owner_dc;
  assign dc_done   = (state == ST_DONE) &  owner_dc;

  // Only the dcache ever writes back, so WDATA implies dcache ownership.
  assign dc_wnext  = (state == ST_WDATA) & bus.bus_reqack;

endmodule

// File: tb/tb_cache_bus_arbiter.sv
// Randomized bench for cache_bus_arbiter with a transaction-level reference model.
// Latency: n/a (testbench).
// Backpressure: the bench plays the memory slave with random or fixed-stall acks and foreign-tag responses.
module tb_cache_bus_arbiter;
  import cache_bus_pkg::*;

  localparam int WIDTH = 64;
  localparam int BEATS = 8;
  localparam int TAGW  = 13;

  localparam int P_IDLE = 0, P_ADDR = 1, P_WR = 2, P_RD = 3, P_DONE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic             ic_req, ic_rvalid, ic_done;
  logic [WIDTH-1:0] ic_addr, ic_rdata;
  logic             dc_req, dc_we, dc_wnext, dc_rvalid, dc_done;
  logic [WIDTH-1:0] dc_addr, dc_wdata, dc_rdata;

  cache_bus_arbiter_if #(.WIDTH(WIDTH), .TAGW(TAGW)) bus_if ();

  cache_bus_arbiter #(.WIDTH(WIDTH), .BEATS(BEATS), .TAGW(TAGW)) dut (
    .clk       (clk),
    .reset     (reset),
    .ic_req    (ic_req),
    .ic_addr   (ic_addr),
    .ic_rdata  (ic_rdata),
    .ic_rvalid (ic_rvalid),
    .ic_done   (ic_done),
    .dc_req    (dc_req),
    .dc_we     (dc_we),
    .dc_addr   (dc_addr),
    .dc_wdata  (dc_wdata),
    .dc_wnext  (dc_wnext),
    .dc_rdata  (dc_rdata),
    .dc_rvalid (dc_rvalid),
    .dc_done   (dc_done),
    .bus       (bus_if)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: one abstract transaction in flight.
  int          m_ph = P_IDLE;
  bit          m_owner_dc, m_we;
  bit          m_last_dc = 1'b1;
  logic [63:0] m_addr;
  int          m_beats;

  // Requester agents.
  bit          ic_pend, dc_pend, ic_mute, dc_mute, dc_w;
  logic [63:0] ic_a, dc_a;

  // Stimulus knobs.
  int p_new = 0, p_ack = 100, p_resp = 100, p_foreign = 0, p_mute = 0;
  int ack_stall = 0, stall_cnt = 0;
  bit do_reset = 1'b1;

  // Observed DUT pulses for the current transaction, and completion order.
  int obs_ic_rv, obs_dc_rv, obs_wnext;
  bit done_q[$];

  function automatic bit chance(input int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic cycle();
    bit          ack, match;
    logic [12:0] itag;
    logic [63:0] e_req;

    @(posedge clk);
    #1;
    reset = do_reset;
    itag  = make_tag(m_we, m_owner_dc ? ID_DC : ID_IC);

    if ((m_ph == P_WR || m_ph == P_RD) && chance(p_mute)) begin
      if (m_owner_dc) dc_mute = 1'b1;
      else            ic_mute = 1'b1;
    end
    if (!ic_pend && chance(p_new)) begin
      ic_pend = 1'b1;
      ic_a    = {$urandom, $urandom};
    end
    if (!dc_pend && chance(p_new)) begin
      dc_pend = 1'b1;
      dc_a    = {$urandom, $urandom};
      dc_w    = 1'($urandom_range(1));
    end
    ic_req   = ic_pend & ~ic_mute;
    ic_addr  = ic_a;
    dc_req   = dc_pend & ~dc_mute;
    dc_we    = dc_w;
    dc_addr  = dc_a;
    dc_wdata = {$urandom, $urandom};

    if (ack_stall > 0) begin
      ack       = (stall_cnt == ack_stall);
      stall_cnt = ack ? 0 : stall_cnt + 1;
    end else begin
      ack = chance(p_ack);
    end
    bus_if.bus_reqack  = ack;
    bus_if.bus_respcyc = chance(p_resp);
    bus_if.bus_resp    = {$urandom, $urandom};
    if (chance(p_foreign))
      bus_if.bus_resptag = {1'($urandom_range(1)), (itag[11:0] == ID_IC) ? ID_DC : ID_IC};
    else
      bus_if.bus_resptag = itag;

    @(negedge clk);
    match = (m_ph == P_RD) && bus_if.bus_respcyc && (bus_if.bus_resptag == itag);
    e_req = (m_ph == P_ADDR) ? m_addr : (m_ph == P_WR) ? dc_wdata : 64'h0;

    check("bus_reqcyc", bus_if.bus_reqcyc, (m_ph == P_ADDR || m_ph == P_WR));
    check("bus_req", bus_if.bus_req, e_req);
    check("bus_reqtag", bus_if.bus_reqtag, (m_ph == P_ADDR || m_ph == P_WR) ? itag : 13'h0);
    check("bus_respack", bus_if.bus_respack, match);
    check("ic_rvalid", ic_rvalid, match && !m_owner_dc);
    check("ic_rdata", ic_rdata, (match && !m_owner_dc) ? bus_if.bus_resp : 64'h0);
    check("dc_rvalid", dc_rvalid, match && m_owner_dc);
    check("dc_rdata", dc_rdata, (match && m_owner_dc) ? bus_if.bus_resp : 64'h0);
    check("ic_done", ic_done, (m_ph == P_DONE) && !m_owner_dc);
    check("dc_done", dc_done, (m_ph == P_DONE) && m_owner_dc);
    check("dc_wnext", dc_wnext, (m_ph == P_WR) && ack);

    obs_ic_rv += int'(ic_rvalid);
    obs_dc_rv += int'(dc_rvalid);
    obs_wnext += int'(dc_wnext);
    if (ic_done) done_q.push_back(1'b0);
    if (dc_done) done_q.push_back(1'b1);

    if (do_reset) begin
      m_ph      = P_IDLE;
      m_last_dc = 1'b1;
      ic_pend   = 1'b0;
      dc_pend   = 1'b0;
      ic_mute   = 1'b0;
      dc_mute   = 1'b0;
      obs_ic_rv = 0;
      obs_dc_rv = 0;
      obs_wnext = 0;
    end else begin
      case (m_ph)
        P_IDLE: begin
          if (ic_req || dc_req) begin
            // On a tie the requester not served last wins; alone, a requester always wins.
`ifdef ARB_FIXED_PRIO_EN
            m_owner_dc = dc_req;
`else
            m_owner_dc = (ic_req && dc_req) ? !m_last_dc : dc_req;
`endif
            m_we    = m_owner_dc && dc_we;
            m_addr  = (m_owner_dc ? dc_addr : ic_addr) & ~64'h3F;
            m_beats = 0;
            m_ph    = P_ADDR;
          end
        end
        P_ADDR: if (ack) m_ph = m_we ? P_WR : P_RD;
        P_WR, P_RD: begin
          if ((m_ph == P_WR) ? ack : match) begin
            m_beats++;
            if (m_beats == BEATS) m_ph = P_DONE;
          end
        end
        default: begin
          check("owner_beats", m_owner_dc ? (m_we ? obs_wnext : obs_dc_rv) : obs_ic_rv, BEATS);
          check("nonowner_beats", m_owner_dc ? obs_ic_rv : (obs_dc_rv + obs_wnext), 0);
          m_last_dc = m_owner_dc;
          if (m_owner_dc) begin dc_pend = 1'b0; dc_mute = 1'b0; end
          else            begin ic_pend = 1'b0; ic_mute = 1'b0; end
          obs_ic_rv = 0;
          obs_dc_rv = 0;
          obs_wnext = 0;
          m_ph      = P_IDLE;
        end
      endcase
    end
  endtask

  task automatic run_until_idle(input int budget);
    for (int i = 0; i < budget; i++) begin
      cycle();
      if (m_ph == P_IDLE && !ic_pend && !dc_pend) return;
    end
    check("timeout_idle", 1, 0);
  endtask

  task automatic apply_reset();
    do_reset = 1'b1;
    cycle();
    cycle();
    do_reset = 1'b0;
  endtask

  initial begin
    reset   = 1'b1;
    ic_req  = 1'b0; ic_addr = '0;
    dc_req  = 1'b0; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
    bus_if.bus_reqack  = 1'b0;
    bus_if.bus_respcyc = 1'b0;
    bus_if.bus_resp    = '0;
    bus_if.bus_resptag = '0;

    // Reset state: every output low.
    apply_reset();

    // Single icache fill of line 0x1040.
    ic_pend = 1'b1; ic_a = 64'h1040;
    run_until_idle(100);

    // Simultaneous requests right after reset.
    apply_reset();
    done_q.delete();
    ic_pend = 1'b1; ic_a = 64'h4000;
    dc_pend = 1'b1; dc_a = 64'h5000; dc_w = 1'b0;
    run_until_idle(200);
    check("served_count", done_q.size(), 2);
    if (done_q.size() == 2) begin
`ifdef ARB_FIXED_PRIO_EN
      check("serve_order", {done_q[0], done_q[1]}, 2'b10);
`else
      check("serve_order", {done_q[0], done_q[1]}, 2'b01);
`endif
    end

    // Writeback to line 0x2000 with three stall cycles before each ack.
    dc_pend = 1'b1; dc_a = 64'h2000; dc_w = 1'b1;
    ack_stall = 3; stall_cnt = 0;
    run_until_idle(200);
    ack_stall = 0;

    // Fill with foreign-tag responses interleaved.
    ic_pend = 1'b1; ic_a = 64'h7044;
    p_resp = 90; p_foreign = 40;
    run_until_idle(300);

    // Reset during the fourth fill beat, then a fresh fill.
    p_resp = 100; p_foreign = 0;
    ic_pend = 1'b1; ic_a = 64'h3000;
    for (int i = 0; i < 50 && obs_ic_rv < 3; i++) cycle();
    check("pre_reset_beats", obs_ic_rv, 3);
    do_reset = 1'b1;
    cycle();
    do_reset = 1'b0;
    cycle();
    check("post_reset_idle_reqcyc", bus_if.bus_reqcyc, 0);
    ic_pend = 1'b1; ic_a = 64'h3080;
    run_until_idle(100);

    // Random traffic with stalls, foreign tags and mid-transaction request drops.
    p_new = 30; p_ack = 50; p_resp = 60; p_foreign = 25; p_mute = 5;
    for (int i = 0; i < 3000; i++) cycle();
    p_new = 0;
    run_until_idle(1000);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

endmodule
